game_sound_sched: RTL

Sound-effect scheduler that shares the board's single speaker pin between game events raised by the game controller: wall bounce, paddle hit, point scored and match won. It latches event pulses, arbitrates by fixed priority, and generates a square-wave tone of per-event pitch and duration. A short silent gap follows each sound. It sits between the game controller's event strobes and the audio output pin.

---
 rtl/game_sound_sched.sv | 316 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/game_sound_sched.sv
// game_sound_sched
// Shares one speaker pin between four game sound effects (wall bounce, paddle hit, point
// scored, match won). Event strobes are latched as pending bits, granted by fixed priority
// (win > score > hit > wall) and played as a square wave of per-sound pitch and duration,
// followed by a silent gap. Score and win may preempt a lower sound in PLAY or GAP.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   en              sound enable; 0 mutes, flushes pending events and idles the FSM
//   wall_evt        one-cycle wall-bounce strobe
//   hit_evt         one-cycle paddle-hit strobe
//   score_evt       one-cycle point strobe
//   win_evt         one-cycle match-won strobe
//   spk             square-wave speaker drive
//   busy            high while playing or in the post-sound gap
//   cur_snd         sound playing: 0 none, 1 wall, 2 hit, 3 score, 4 win
//
// Build option: define SOUND_WIN_MELODY_EN to play the win sound as a three-note rising
// melody; otherwise it is a single tone at twice the score pitch for two score lengths.
module game_sound_sched #(
  parameter int unsigned TICK_DIV   = 25000,
  parameter int unsigned WALL_HALF  = 52083,
  parameter int unsigned HIT_HALF   = 26042,
  parameter int unsigned SCORE_HALF = 12500,
  parameter int unsigned WALL_LEN   = 16,
  parameter int unsigned HIT_LEN    = 16,
  parameter int unsigned SCORE_LEN  = 256,
  parameter int unsigned GAP_LEN    = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wall_evt,
  input  logic       hit_evt,
  input  logic       score_evt,
  input  logic       win_evt,
  output logic       spk,
  output logic       busy,
  output logic [2:0] cur_snd
);

  localparam logic [2:0] SndNone  = 3'd0;
  localparam logic [2:0] SndWall  = 3'd1;
  localparam logic [2:0] SndHit   = 3'd2;
  localparam logic [2:0] SndScore = 3'd3;
  localparam logic [2:0] SndWin   = 3'd4;

`ifdef SOUND_WIN_MELODY_EN
  localparam int unsigned WinLen   = SCORE_LEN;
  localparam int unsigned WinHalf0 = SCORE_HALF;
  localparam int unsigned WinHalf1 = SCORE_HALF * 3 / 4;
  localparam int unsigned WinHalf2 = SCORE_HALF / 2;
`else
  localparam int unsigned WinLen   = 2 * SCORE_LEN;
  localparam int unsigned WinHalf0 = SCORE_HALF / 2;
`endif

  // Win half-periods never exceed SCORE_HALF, so they do not widen the half counter.
  localparam int unsigned HalfMax0 = (WALL_HALF > HIT_HALF) ? WALL_HALF : HIT_HALF;
  localparam int unsigned HalfMax  = (HalfMax0 > SCORE_HALF) ? HalfMax0 : SCORE_HALF;
  localparam int unsigned LenMax0  = (WALL_LEN > HIT_LEN) ? WALL_LEN : HIT_LEN;
  localparam int unsigned LenMax1  = (LenMax0 > WinLen) ? LenMax0 : WinLen;
  localparam int unsigned LenMax2  = (LenMax1 > SCORE_LEN) ? LenMax1 : SCORE_LEN;
  localparam int unsigned LenMax   = (LenMax2 > GAP_LEN) ? LenMax2 : GAP_LEN;

  localparam int unsigned DivW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HalfW = (HalfMax > 1) ? $clog2(HalfMax) : 1;
  localparam int unsigned LenW  = (LenMax > 1) ? $clog2(LenMax) : 1;

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  state_e            state_q, state_d;
  logic [3:0]        pend_q, pend_d;      // {win, score, hit, wall}
  logic [2:0]        snd_q, snd_d;        // last granted sound, kept through GAP for preemption
  logic [DivW-1:0]   div_q, div_d;
  logic [LenW-1:0]   tick_q, tick_d;
  logic [HalfW-1:0]  half_q, half_d;
  logic              spk_q, spk_d;
  logic              busy_q, busy_d;
  logic [2:0]        cur_snd_q, cur_snd_d;
`ifdef SOUND_WIN_MELODY_EN
  logic [1:0]        note_q, note_d;
`endif

  logic [3:0]        evt;
  logic [2:0]        grant_snd;
  logic [3:0]        grant_mask;
  logic              preempt;
  logic              do_grant;
  logic              last_note;
  logic [HalfW-1:0]  half_lim;
  logic [LenW-1:0]   len_lim;
  logic              tick_end;
  logic              dur_done;

  assign evt = {win_evt, score_evt, hit_evt, wall_evt};

  // Highest pending request and its bit.
  always_comb begin
    grant_snd  = SndNone;
    grant_mask = 4'b0000;
    if (pend_q[3]) begin
      grant_snd  = SndWin;
      grant_mask = 4'b1000;
    end else if (pend_q[2]) begin
      grant_snd  = SndScore;
      grant_mask = 4'b0100;
    end else if (pend_q[1]) begin
      grant_snd  = SndHit;
      grant_mask = 4'b0010;
    end else if (pend_q[0]) begin
      grant_snd  = SndWall;
      grant_mask = 4'b0001;
    end
  end

  // Only score and win can abort a lower-priority sound.
  assign preempt = (pend_q[3] && (snd_q != SndWin)) ||
                   (pend_q[2] && (snd_q != SndWin) && (snd_q != SndScore));

`ifdef SOUND_WIN_MELODY_EN
  assign last_note = (snd_q != SndWin) || (note_q == 2'd2);
`else
  assign last_note = 1'b1;
`endif

  // Per-sound pitch and duration limits (both stored as value-1).
  always_comb begin
    half_lim = HalfW'(WALL_HALF - 1);
    len_lim  = LenW'(WALL_LEN - 1);
    case (snd_q)
      SndHit: begin
        half_lim = HalfW'(HIT_HALF - 1);
        len_lim  = LenW'(HIT_LEN - 1);
      end
      SndScore: begin
        half_lim = HalfW'(SCORE_HALF - 1);
        len_lim  = LenW'(SCORE_LEN - 1);
      end
      SndWin: begin
        len_lim = LenW'(WinLen - 1);
`ifdef SOUND_WIN_MELODY_EN
        case (note_q)
          2'd0:    half_lim = HalfW'(WinHalf0 - 1);
          2'd1:    half_lim = HalfW'(WinHalf1 - 1);
          default: half_lim = HalfW'(WinHalf2 - 1);
        endcase
`else
        half_lim = HalfW'(WinHalf0 - 1);
`endif
      end
      default: ;
    endcase
    if (state_q == StGap) begin
      len_lim = LenW'(GAP_LEN - 1);
    end
  end

  assign tick_end = (div_q == DivW'(TICK_DIV - 1));
  assign dur_done = tick_end && (tick_q == len_lim);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    do_grant = 1'b0;
    if (!en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|pend_q) begin
            state_d  = StPlay;
            do_grant = 1'b1;
          end
        end
        StPlay: begin
          if (preempt) begin
            do_grant = 1'b1;
          end else if (dur_done && last_note) begin
            state_d = StGap;
          end
        end
        StGap: begin
          if (preempt) begin
            state_d  = StPlay;
            do_grant = 1'b1;
          end else if (dur_done) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output and datapath next-state logic.
  always_comb begin
    // A strobe in the same cycle as its grant re-arms the bit.
    pend_d    = en ? ((pend_q & ~(do_grant ? grant_mask : 4'b0000)) | evt) : 4'b0000;
    snd_d     = snd_q;
    div_d     = div_q;
    tick_d    = tick_q;
    half_d    = half_q;
    spk_d     = spk_q;
    busy_d    = busy_q;
    cur_snd_d = cur_snd_q;
`ifdef SOUND_WIN_MELODY_EN
    note_d    = note_q;
`endif
    if (!en) begin
      snd_d     = SndNone;
      div_d     = '0;
      tick_d    = '0;
      half_d    = '0;
      spk_d     = 1'b0;
      busy_d    = 1'b0;
      cur_snd_d = SndNone;
`ifdef SOUND_WIN_MELODY_EN
      note_d    = 2'd0;
`endif
    end else if (do_grant) begin
      snd_d     = grant_snd;
      cur_snd_d = grant_snd;
      div_d     = '0;
      tick_d    = '0;
      half_d    = '0;
      spk_d     = 1'b1;
      busy_d    = 1'b1;
`ifdef SOUND_WIN_MELODY_EN
      note_d    = 2'd0;
`endif
    end else if (state_q == StPlay) begin
      if (dur_done) begin
        div_d  = '0;
        tick_d = '0;
        half_d = '0;
        if (last_note) begin
          spk_d     = 1'b0;
          cur_snd_d = SndNone;
        end else begin
          // Next melody note starts on a fresh high phase.
          spk_d = 1'b1;
`ifdef SOUND_WIN_MELODY_EN
          note_d = note_q + 2'd1;
`endif
        end
      end else begin
        if (tick_end) begin
          div_d  = '0;
          tick_d = tick_q + LenW'(1);
        end else begin
          div_d = div_q + DivW'(1);
        end
        if (half_q == half_lim) begin
          half_d = '0;
          spk_d  = ~spk_q;
        end else begin
          half_d = half_q + HalfW'(1);
        end
      end
    end else if (state_q == StGap) begin
      if (dur_done) begin
        div_d  = '0;
        tick_d = '0;
        busy_d = 1'b0;
      end else if (tick_end) begin
        div_d  = '0;
        tick_d = tick_q + LenW'(1);
      end else begin
        div_d = div_q + DivW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q    <= 4'b0000;
      snd_q     <= SndNone;
      div_q     <= '0;
      tick_q    <= '0;
      half_q    <= '0;
      spk_q     <= 1'b0;
      busy_q    <= 1'b0;
      cur_snd_q <= SndNone;
`ifdef SOUND_WIN_MELODY_EN
      note_q    <= 2'd0;
`endif
    end else begin
      pend_q    <= pend_d;
      snd_q     <= snd_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      half_q    <= half_d;
      spk_q     <= spk_d;
      busy_q    <= busy_d;
      cur_snd_q <= cur_snd_d;
`ifdef SOUND_WIN_MELODY_EN
      note_q    <= note_d;
`endif
    end
  end

  assign spk     = spk_q;
  assign busy    = busy_q;
  assign cur_snd = cur_snd_q;

endmodule
